// File: rtl/xor_share_arbiter.sv
// Round-robin arbiter sharing one XOR unit among NUM_REQ requesters.
// Optional WAIT-state watchdog enabled by defining ARB_TIMEOUT_EN.
module xor_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 1,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_enable,
  input  logic [NUM_REQ*DATA_W-1:0] req_a_data,
  input  logic [NUM_REQ*DATA_W-1:0] req_b_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_enable,
  output logic [NUM_REQ*DATA_W-1:0] rsp_data,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         A_data,
  output logic                      A_enable,
  input  logic                      A_ready,
  output logic [DATA_W-1:0]         B_data,
  output logic                      B_enable,
  input  logic                      B_ready,
  input  logic [DATA_W-1:0]         Y_data,
  input  logic                      Y_enable,
  output logic                      Y_ready,
  output logic                      timeout_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     last_q, last_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic              a_done_q, a_done_d;
  logic              b_done_q, b_done_d;
  logic [IW-1:0]     win;
  logic              found;
  int                j;

  // Search starts just past the last served slot so every requester rotates.
  always_comb begin
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(last_q) + k) % NUM_REQ;
      if (!found && req_enable[j]) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo;
  assign tmo = (state_q == S_WAIT) && !Y_enable
             && (cnt_q == CW'(TIMEOUT - 1));
  assign timeout_err = tmo;
`else
  assign timeout_err = 1'b0;
`endif

  assign A_enable = (state_q == S_ISSUE) && !a_done_q;
  assign B_enable = (state_q == S_ISSUE) && !b_done_q;
  assign A_data   = a_q;
  assign B_data   = b_q;
  assign Y_ready  = (state_q == S_WAIT);

  always_comb begin
    req_ready  = '0;
    rsp_enable = '0;
    rsp_data   = '0;
    if (state_q == S_IDLE && found && !reset)
      req_ready[win] = 1'b1;
    if (state_q == S_RESP) begin
      rsp_enable[idx_q] = 1'b1;
      rsp_data[int'(idx_q)*DATA_W +: DATA_W] = y_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    y_d      = y_q;
    a_done_d = a_done_q;
    b_done_d = b_done_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          a_d      = req_a_data[int'(win)*DATA_W +: DATA_W];
          b_d      = req_b_data[int'(win)*DATA_W +: DATA_W];
          idx_d    = win;
          a_done_d = 1'b0;
          b_done_d = 1'b0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        a_done_d = a_done_q | A_ready;
        b_done_d = b_done_q | B_ready;
        if (a_done_d && b_done_d) begin
          state_d = S_WAIT;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_WAIT: begin
        if (Y_enable) begin
          y_d     = Y_data;
          state_d = S_RESP;
        end
`ifdef ARB_TIMEOUT_EN
        else if (tmo) begin
          y_d     = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready[idx_q]) begin
          last_d  = idx_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      last_q   <= IW'(NUM_REQ - 1);
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      y_q      <= '0;
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      y_q      <= y_d;
      a_done_q <= a_done_d;
      b_done_q <= b_done_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_xor_share_arbiter.sv
// Directed bench for xor_share_arbiter (NUM_REQ=4, DATA_W=1).
// Unit handshakes are driven by hand, step by step.
module tb_xor_share_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req_enable = '0;
  logic [3:0] req_a_data = '0;
  logic [3:0] req_b_data = '0;
  logic [3:0] req_ready;
  logic [3:0] rsp_enable;
  logic [3:0] rsp_data;
  logic [3:0] rsp_ready = '0;
  logic [0:0] A_data, B_data;
  logic       A_enable, B_enable;
  logic       A_ready = 1'b0;
  logic       B_ready = 1'b0;
  logic [0:0] Y_data = '0;
  logic       Y_enable = 1'b0;
  logic       Y_ready;
  logic       timeout_err;

  int n_chk = 0;
  int n_fail = 0;
  int a_xf = 0;
  int b_xf = 0;

  always #5 clk = ~clk;

  xor_share_arbiter #(
    .NUM_REQ(4), .DATA_W(1), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset),
    .req_enable(req_enable),
    .req_a_data(req_a_data),
    .req_b_data(req_b_data),
    .req_ready(req_ready),
    .rsp_enable(rsp_enable),
    .rsp_data(rsp_data),
    .rsp_ready(rsp_ready),
    .A_data(A_data), .A_enable(A_enable),
    .A_ready(A_ready),
    .B_data(B_data), .B_enable(B_enable),
    .B_ready(B_ready),
    .Y_data(Y_data), .Y_enable(Y_enable),
    .Y_ready(Y_ready),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (A_enable && A_ready) a_xf++;
    if (B_enable && B_ready) b_xf++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input int slot, input logic y);
    logic [3:0] oh;
    oh = 4'b0001 << slot;
    #1;
    chk("txn_grant", req_ready, oh);
    tick();
    A_ready = 1'b1;
    B_ready = 1'b1;
    chk("txn_issue", A_enable, 1);
    tick();
    A_ready = 1'b0;
    B_ready = 1'b0;
    chk("txn_wait", Y_ready, 1);
    Y_enable = 1'b1;
    Y_data   = y;
    tick();
    Y_enable = 1'b0;
    chk("txn_rsp_en", rsp_enable, oh);
    chk("txn_rsp_data", rsp_data, y ? oh : 4'b0000);
    rsp_ready = 4'b1111;
    tick();
    rsp_ready = 4'b0000;
  endtask

  initial begin
    req_enable = 4'b1111;
    #3;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_enable", rsp_enable, 0);
    chk("rst_ab_en", {A_enable, B_enable}, 0);
    chk("rst_y_ready", Y_ready, 0);
    chk("rst_tmo", timeout_err, 0);
    req_enable = 4'b0000;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // single request, slot 2, a=1 b=0
    req_enable = 4'b0100;
    req_a_data = 4'b0100;
    req_b_data = 4'b0000;
    #1;
    chk("t1_grant", req_ready, 4'b0100);
    tick();
    req_enable = 4'b0000;
    chk("t1_busy_ready", req_ready, 0);
    chk("t1_ab_en", {A_enable, B_enable}, 2'b11);
    chk("t1_ab_data", {A_data, B_data}, 2'b10);
    chk("t1_yr_issue", Y_ready, 0);
    A_ready = 1'b1;
    B_ready = 1'b1;
    tick();
    A_ready = 1'b0;
    B_ready = 1'b0;
    chk("t1_ab_drop", {A_enable, B_enable}, 0);
    chk("t1_wait_yr", Y_ready, 1);
    Y_enable = 1'b1;
    Y_data   = 1'b1;
    tick();
    Y_enable = 1'b0;
    chk("t1_yr_resp", Y_ready, 0);
    chk("t1_rsp_en", rsp_enable, 4'b0100);
    chk("t1_rsp_data", rsp_data, 4'b0100);
    rsp_ready = 4'b0100;
    tick();
    rsp_ready = 4'b0000;
    chk("t1_idle_rsp", rsp_enable, 0);

    // Y=0 path, a=b=1
    req_enable = 4'b0100;
    req_b_data = 4'b0100;
    run_txn(2, 1'b0);
    req_enable = 4'b0000;

    // fairness from a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_enable = 4'b1111;
    run_txn(0, 1'b1);
    run_txn(1, 1'b1);
    run_txn(2, 1'b0);
    run_txn(3, 1'b1);
    run_txn(0, 1'b0);
    req_enable = 4'b0000;

    // B channel delayed 3 cycles behind A
    a_xf = 0;
    b_xf = 0;
    req_enable = 4'b1000;
    #1;
    chk("t3_grant", req_ready, 4'b1000);
    tick();
    req_enable = 4'b0000;
    A_ready = 1'b1;
    chk("t3_ab_en", {A_enable, B_enable}, 2'b11);
    tick();
    chk("t3_c2", {A_enable, B_enable}, 2'b01);
    tick();
    chk("t3_c3", {A_enable, B_enable}, 2'b01);
    tick();
    chk("t3_c4", {A_enable, B_enable}, 2'b01);
    chk("t3_c4_yr", Y_ready, 0);
    B_ready = 1'b1;
    tick();
    A_ready = 1'b0;
    B_ready = 1'b0;
    chk("t3_wait", {Y_ready, A_enable, B_enable}, 3'b100);
    chk("t3_a_xfers", a_xf, 1);
    chk("t3_b_xfers", b_xf, 1);
    Y_enable = 1'b1;
    Y_data   = 1'b0;
    tick();
    Y_enable = 1'b0;
    chk("t3_rsp_en", rsp_enable, 4'b1000);
    rsp_ready = 4'b1000;
    tick();
    rsp_ready = 4'b0000;

    // response back-pressure on slot 1
    req_enable = 4'b0010;
    req_a_data = 4'b0010;
    req_b_data = 4'b0000;
    #1;
    chk("t4_grant", req_ready, 4'b0010);
    tick();
    req_enable = 4'b0000;
    A_ready = 1'b1;
    B_ready = 1'b1;
    tick();
    A_ready = 1'b0;
    B_ready = 1'b0;
    Y_enable = 1'b1;
    Y_data   = 1'b1;
    tick();
    Y_enable = 1'b0;
    req_enable = 4'b0001;
    req_a_data = 4'b0001;
    rsp_ready  = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_hold_en", rsp_enable, 4'b0010);
      chk("t4_hold_data", rsp_data, 4'b0010);
      chk("t4_hold_req", req_ready, 0);
      tick();
    end
    rsp_ready = 4'b0010;
    tick();
    rsp_ready = 4'b0000;
    chk("t4_next_grant", req_ready, 4'b0001);

    // reset during WAIT
    tick();
    req_enable = 4'b0000;
    A_ready = 1'b1;
    B_ready = 1'b1;
    tick();
    A_ready = 1'b0;
    B_ready = 1'b0;
    chk("t5_wait", Y_ready, 1);
    chk("t5_a_data", A_data, 1);
    req_enable = 4'b1111;
    #2;
    reset = 1'b1;
    #1;
    chk("t5_rst_req", req_ready, 0);
    chk("t5_rst_ab", {A_enable, B_enable, A_data}, 0);
    chk("t5_rst_y", Y_ready, 0);
    chk("t5_rst_rsp", {rsp_enable, rsp_data}, 0);
    chk("t5_rst_tmo", timeout_err, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("t5_first_grant", req_ready, 4'b0001);
    run_txn(0, 1'b1);
    req_enable = 4'b0000;

    // unit never answers
    req_enable = 4'b0100;
    #1;
    chk("t6_grant", req_ready, 4'b0100);
    tick();
    req_enable = 4'b0000;
    A_ready = 1'b1;
    B_ready = 1'b1;
    tick();
    A_ready = 1'b0;
    B_ready = 1'b0;
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      chk("t6_pre_tmo", {Y_ready, timeout_err}, 2'b10);
      tick();
    end
    chk("t6_tmo_pulse", timeout_err, 1);
    tick();
    chk("t6_tmo_clear", {timeout_err, Y_ready}, 0);
    chk("t6_rsp_en", rsp_enable, 4'b0100);
    chk("t6_rsp_data", rsp_data, 0);
    rsp_ready = 4'b0100;
    tick();
    rsp_ready = 4'b0000;
`else
    for (int k = 0; k < 20; k++) begin
      chk("t6_stuck", {Y_ready, timeout_err, rsp_enable}, 6'b100000);
      tick();
    end
    Y_enable = 1'b1;
    Y_data   = 1'b1;
    tick();
    Y_enable = 1'b0;
    chk("t6_rsp_en", rsp_enable, 4'b0100);
    chk("t6_rsp_data", rsp_data, 4'b0100);
    rsp_ready = 4'b0100;
    tick();
    rsp_ready = 4'b0000;
`endif
    chk("t6_idle", {rsp_enable, Y_ready}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_share_arbiter.md
Name: xor_share_arbiter

Overview:
- Round-robin arbiter that shares one XOR compute unit (A/B input channels, Y output channel, enable/ready handshake) among NUM_REQ requesters.
- Each requester submits an operand pair; the arbiter issues it to the unit, collects Y and returns it to the same requester.
- Sits between the requester-side logic and the shared XOR unit instance.
- One transaction in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 1, operand/result width
- TIMEOUT, 16, WAIT-state cycle limit (used only with ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_enable  in  NUM_REQ  per-requester request valid
- req_a_data  in  NUM_REQ*DATA_W  operand A, slot i at [i*DATA_W +: DATA_W]
- req_b_data  in  NUM_REQ*DATA_W  operand B, same packing
- req_ready  out  NUM_REQ  one-hot grant/accept
- rsp_enable  out  NUM_REQ  per-requester result valid
- rsp_data  out  NUM_REQ*DATA_W  result, same packing; non-granted slots 0
- rsp_ready  in  NUM_REQ  per-requester result accept
- A_data  out  DATA_W  to unit
- A_enable  out  1  to unit
- A_ready  in  1  from unit
- B_data  out  DATA_W  to unit
- B_enable  out  1  to unit
- B_ready  in  1  from unit
- Y_data  in  DATA_W  from unit
- Y_enable  in  1  from unit
- Y_ready  out  1  to unit
- timeout_err  out  1  one-cycle pulse on WAIT timeout; tied 0 without ARB_TIMEOUT_EN

Behaviour:
- Transfer on any channel = enable & ready high at a rising clk edge.
- Reset (any time, including mid-transaction): state=IDLE, last_grant=NUM_REQ-1, all outputs 0, latched operands/result 0. In-flight work is dropped; the unit shares the same reset.
- FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req_enable is high, winner = first set bit searching from last_grant+1 upward, with wrap.
  - req_ready[winner]=1 combinationally in the same cycle; at the edge, latch a/b/winner index and go to ISSUE.
  - No request: stay in IDLE, req_ready=0.
  - A requester dropping enable before grant is legal; nothing is latched for it.
- ISSUE:
  - A_enable stays high until the A transfer; B_enable stays high until the B transfer. The two channels complete independently, each tracked by a done flag.
  - When both are done (same cycle allowed), go to WAIT. An enable never reasserts after its own transfer.
- WAIT: Y_ready=1. On a Y transfer, latch Y_data and go to RESP. Y_ready=0 in every other state.
- RESP:
  - rsp_enable[idx]=1 and rsp_data slot idx=result, held stable until rsp_ready[idx].
  - Then last_grant=idx and go to IDLE. rsp_ready on other slots is ignored.
- req_ready is 0 outside IDLE, so new requests are never accepted while busy.
- Minimum latency is 4 cycles from grant to rsp_enable when the unit answers immediately: grant edge, ISSUE 1 cycle, WAIT ≥1 cycle, RESP.
- Fairness: with all requesters asserting, grants rotate 0,1,2,3,0,...

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle without Y_enable. On the TIMEOUT-th such cycle:
  - latch result=0
  - pulse timeout_err for 1 cycle
  - go to RESP
  - set Y_ready=0 from then on
- A Y_enable in that same cycle takes priority: normal capture, no error.
- Not defined: no counter; WAIT waits indefinitely; timeout_err=0.

Test Plan:
- Reset, then single request on slot 2 with a=1, b=0 -> req_ready=4'b0100 for 1 cycle, A/B issued with data 1/0, rsp_enable=4'b0100, rsp_data slot2=1; Y=0 path with a=b=1 returns 0.
- All four req_enable held high, rsp_ready always 1 -> grant order 0,1,2,3,0; no requester granted twice before others.
- A_ready high at cycle n, B_ready delayed 3 cycles -> A_enable drops after 1 transfer, B_enable held 4 cycles, exactly one transfer per channel.
- rsp_ready[1] held low 5 cycles while in RESP for slot 1 -> rsp_enable/rsp_data stable for all 5 cycles; req_ready stays 0 even though slot 0 requests.
- Assert reset during WAIT -> all outputs 0 asynchronously; after release, next request from slot 0 wins first.
- With ARB_TIMEOUT_EN, TIMEOUT=16, unit never asserts Y_enable -> timeout_err pulses on the 16th WAIT cycle, rsp_data=0 returned; without the macro, the arbiter stays in WAIT.
